rv32i_id_top: RTL and testbench
===============================

Name: rv32i_id_top

Overview:
- Decode stage of the RV32I pipeline, directly downstream of the fetch stage.
- Takes the instruction word and PC that fetch presents each cycle, reads the 32x32 register file, and resolves JAL/JALR/branches.
- Returns jump_enable/jump_addr to fetch, squashes the one wrong-path instruction that follows a taken jump, and registers decoded operands for the execute stage.

Parameters:
- SQUASH_NOP, 32'h00000013: instruction word driven on iw_out for squashed or reset slots (ADDI x0,x0,0).
- RF_RESET, 1: 1 = register file array cleared by reset; 0 = array not reset (x0 still reads zero).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- iw_in  input  32  instruction word from fetch
- pc_in  input  32  PC of iw_in, from fetch
- wb_enable  input  1  writeback strobe
- wb_reg  input  5  writeback destination register
- wb_data  input  32  writeback data
- ex_fwd_enable  input  1  EX result valid for forwarding (used only with the optional feature)
- ex_fwd_reg  input  5  EX destination register
- ex_fwd_data  input  32  EX result
- jump_enable  output  1  to fetch; combinational; redirect PC next edge
- jump_addr  output  32  to fetch; combinational; redirect target
- iw_out  output  32  registered instruction word to EX
- pc_out  output  32  registered PC to EX
- rs1_data_out  output  32  registered rs1 value
- rs2_data_out  output  32  registered rs2 value
- wb_reg_out  output  5  registered rd
- wb_enable_out  output  1  registered: instruction writes rd
- valid_out  output  1  registered: slot holds a live instruction
- illegal_out  output  1  registered: opcode not RV32I

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on reset. All registered outputs and the squash flag reset on assertion, independent of clk.
- Reset values: iw_out=SQUASH_NOP; pc_out, rs1_data_out, rs2_data_out, wb_reg_out = 0; wb_enable_out, valid_out, illegal_out, squash = 0.
- With RF_RESET=1, x1..x31 are cleared by reset.
- Register file: x0 always reads 0. Write at posedge when wb_enable && wb_reg!=0. Reads are combinational with write-through: if wb_enable && wb_reg==rs && rs!=0, the read returns wb_data in the same cycle.
- Immediates are sign-extended to 32 bits per the I/S/B/U/J formats. All address arithmetic is modulo 2^32 (wraps, no flag).
- Jump resolution is combinational from iw_in/pc_in and suppressed when squash=1:
  - JAL (7'b1101111): jump, addr = pc_in + J-imm.
  - JALR (7'b1100111, funct3=000): jump, addr = (rs1 + I-imm) & ~32'h1.
  - BRANCH (7'b1100011): BEQ/BNE/BLT/BGE (signed) and BLTU/BGEU (unsigned) compare rs1 vs rs2. Jump when taken, addr = pc_in + B-imm. Not taken: jump_enable=0. funct3 010/011 is illegal and never jumps.
  - jump_addr = 0 whenever jump_enable=0.
- Squash: squash <= jump_enable at each posedge. Fetch has already fetched pc_in+4 when a jump resolves, so the next cycle's iw_in is wrong-path.
  - When squash=1 the EX slot loads: iw_out=SQUASH_NOP, valid_out=0, wb_enable_out=0, illegal_out=0, wb_reg_out=0.
  - pc_out still loads pc_in.
  - jump_enable is forced 0 during squash, so back-to-back jumps cannot chain through a squashed slot.
- Pipeline registers (1-cycle latency) when not squashed: iw_out=iw_in, pc_out=pc_in, rs1/rs2 data = register-file reads, wb_reg_out=rd, valid_out=1.
- wb_enable_out=1 for LUI, AUIPC, JAL, JALR, OP-IMM, OP, LOAD with rd!=0. It is 0 for BRANCH, STORE, FENCE, SYSTEM, illegal, or rd==0.
- Illegal opcode: illegal_out=1, wb_enable_out=0, valid_out=1, no jump.
- Reset deasserting mid-stream: the first post-reset iw_in is decoded normally (squash=0).

Optional Feature:
- Macro: RV32I_ID_FWD_EN.
- Defined: operand reads are prioritised as ex_fwd (ex_fwd_enable && ex_fwd_reg==rs && rs!=0), then wb write-through, then array. The forwarded value applies to both the registered operands and JALR/branch resolution.
- Undefined: ex_fwd_* inputs are ignored; reads use wb write-through then array only.

Test Plan:
- Assert reset mid-cycle with live inputs -> all outputs take reset values immediately; iw_out=32'h00000013; valid_out=0.
- wb x5=32'hDEADBEEF while iw_in=ADDI x6,x5,1 -> next cycle rs1_data_out=32'hDEADBEEF, wb_reg_out=6, wb_enable_out=1. Writeback to x0 -> x0 still reads 0.
- JAL x1,+0x20 at pc_in=32'h100 -> same cycle jump_enable=1, jump_addr=32'h120. Next cycle's iw_in (pc 0x104, a JAL) -> valid_out=0 and jump_enable=0.
- x1=5, x2=5: BEQ x1,x2,-8 at pc 0x200 -> jump_addr=32'h1F8. BLT with x1=32'hFFFFFFFF, x2=1 -> taken. BLTU with the same operands -> not taken.
- JALR x0,x3,3 with x3=32'h1000 -> jump_addr=32'h1002 (bit0 cleared). Opcode 7'b0000000 -> illegal_out=1, wb_enable_out=0.
- With RV32I_ID_FWD_EN defined: ex_fwd x7=32'h55 and wb x7=32'h66 in the same cycle -> rs1_data_out=32'h55. Without the macro -> 32'h66.

Source files
------------

// File: rtl/rv32i_id_top.sv
// rv32i_id_top: RV32I decode stage.
//   Sits directly after fetch. Each cycle it reads the 32x32 register file for
//   iw_in and resolves JAL/JALR/branches combinationally. It returns a
//   redirect (jump_enable/jump_addr) to fetch, squashes the single wrong-path
//   instruction that follows a taken jump, and registers the decoded operands
//   for execute.
//
// Optional feature: define RV32I_ID_FWD_EN to give the EX result (ex_fwd_*)
// priority over writeback write-through and the array on operand reads.
// Without the macro the ex_fwd_* inputs are ignored.
//
// Ports:
//   clk, reset                          clock; asynchronous active-high reset
//   iw_in, pc_in                        instruction word and its PC from fetch
//   wb_enable, wb_reg, wb_data          register-file writeback
//   ex_fwd_enable, ex_fwd_reg,
//   ex_fwd_data                         EX-stage forwarding source
//   jump_enable, jump_addr              combinational redirect to fetch
//   iw_out, pc_out                      registered instruction word and PC
//   rs1_data_out, rs2_data_out          registered operand values
//   wb_reg_out, wb_enable_out           registered rd and its write enable
//   valid_out, illegal_out              registered slot-live and illegal flags
//
// Parameters:
//   SQUASH_NOP  word placed on iw_out for squashed and reset slots
//   RF_RESET    1: x1..x31 cleared by reset; 0: array is not reset

module rv32i_id_top #(
  parameter logic [31:0] SQUASH_NOP = 32'h0000_0013,
  parameter int          RF_RESET   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iw_in,
  input  logic [31:0] pc_in,
  input  logic        wb_enable,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        ex_fwd_enable,
  input  logic [4:0]  ex_fwd_reg,
  input  logic [31:0] ex_fwd_data,
  output logic        jump_enable,
  output logic [31:0] jump_addr,
  output logic [31:0] iw_out,
  output logic [31:0] pc_out,
  output logic [31:0] rs1_data_out,
  output logic [31:0] rs2_data_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_enable_out,
  output logic        valid_out,
  output logic        illegal_out
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] imm_j;

  assign opcode = iw_in[6:0];
  assign rd     = iw_in[11:7];
  assign funct3 = iw_in[14:12];
  assign rs1    = iw_in[19:15];
  assign rs2    = iw_in[24:20];
  assign imm_i  = {{20{iw_in[31]}}, iw_in[31:20]};
  assign imm_b  = {{19{iw_in[31]}}, iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
  assign imm_j  = {{11{iw_in[31]}}, iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21], 1'b0};

  // Register file (x0 is not stored)
  logic [31:0] rf [1:31];

  generate
    if (RF_RESET != 0) begin : g_rf_rst
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 1; i < 32; i++) rf[i] <= '0;
        end else if (wb_enable && (wb_reg != 5'd0)) begin
          rf[wb_reg] <= wb_data;
        end
      end
    end else begin : g_rf_norst
      always_ff @(posedge clk) begin
        if (wb_enable && (wb_reg != 5'd0)) rf[wb_reg] <= wb_data;
      end
    end
  endgenerate

  // Read priority: EX forward (optional), then writeback write-through, then array.
  function automatic logic [31:0] read_reg(input logic [4:0] rs);
    logic [31:0] val;
    val = '0;
    if (rs != 5'd0) begin
      val = rf[rs];
      if (wb_enable && (wb_reg == rs)) val = wb_data;
`ifdef RV32I_ID_FWD_EN
      if (ex_fwd_enable && (ex_fwd_reg == rs)) val = ex_fwd_data;
`endif
    end
    return val;
  endfunction

`ifndef RV32I_ID_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{ex_fwd_enable, ex_fwd_reg, ex_fwd_data};
`endif

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  always_comb begin
    rs1_val = read_reg(rs1);
    rs2_val = read_reg(rs2);
  end

  // Decode and jump resolution
  logic        squash;
  logic        illegal;
  logic        writes_rd;
  logic        jump_cand;
  logic        br_taken;
  logic [31:0] target;

  always_comb begin
    illegal   = 1'b0;
    writes_rd = 1'b0;
    jump_cand = 1'b0;
    br_taken  = 1'b0;
    target    = '0;

    unique case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase

    case (opcode)
      OP_LUI, OP_AUIPC, OP_IMM, OP_OP, OP_LOAD: writes_rd = 1'b1;
      OP_STORE, OP_FENCE, OP_SYSTEM: ;
      OP_JAL: begin
        writes_rd = 1'b1;
        jump_cand = 1'b1;
        target    = pc_in + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          writes_rd = 1'b1;
          jump_cand = 1'b1;
          target    = (rs1_val + imm_i) & ~32'h1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        // funct3 010/011 have no branch encoding
        if (funct3[2:1] == 2'b01) begin
          illegal = 1'b1;
        end else begin
          jump_cand = br_taken;
          target    = pc_in + imm_b;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  // The slot after a taken jump is wrong-path, so it can neither jump nor retire.
  assign jump_enable = jump_cand && !squash;
  assign jump_addr   = jump_enable ? target : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      squash        <= 1'b0;
      iw_out        <= SQUASH_NOP;
      pc_out        <= '0;
      rs1_data_out  <= '0;
      rs2_data_out  <= '0;
      wb_reg_out    <= '0;
      wb_enable_out <= 1'b0;
      valid_out     <= 1'b0;
      illegal_out   <= 1'b0;
    end else begin
      squash       <= jump_enable;
      pc_out       <= pc_in;
      rs1_data_out <= rs1_val;
      rs2_data_out <= rs2_val;
      if (squash) begin
        iw_out        <= SQUASH_NOP;
        wb_reg_out    <= '0;
        wb_enable_out <= 1'b0;
        valid_out     <= 1'b0;
        illegal_out   <= 1'b0;
      end else begin
        iw_out        <= iw_in;
        wb_reg_out    <= rd;
        wb_enable_out <= writes_rd && !illegal && (rd != 5'd0);
        valid_out     <= 1'b1;
        illegal_out   <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_id_top.sv
// Bench for rv32i_id_top: directed instruction vectors with hand-computed
// results. The driver pushes the expected EX-slot contents into a queue; a
// monitor pops and compares one cycle later. Combinational redirect outputs
// are compared by the driver in the cycle the instruction is presented.

module tb_rv32i_id_top;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] iw_in = NOP;
  logic [31:0] pc_in = '0;
  logic        wb_enable = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        ex_fwd_enable = 1'b0;
  logic [4:0]  ex_fwd_reg = '0;
  logic [31:0] ex_fwd_data = '0;
  logic        jump_enable;
  logic [31:0] jump_addr;
  logic [31:0] iw_out;
  logic [31:0] pc_out;
  logic [31:0] rs1_data_out;
  logic [31:0] rs2_data_out;
  logic [4:0]  wb_reg_out;
  logic        wb_enable_out;
  logic        valid_out;
  logic        illegal_out;

  rv32i_id_top dut (
    .clk(clk), .reset(reset), .iw_in(iw_in), .pc_in(pc_in),
    .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_fwd_enable(ex_fwd_enable), .ex_fwd_reg(ex_fwd_reg), .ex_fwd_data(ex_fwd_data),
    .jump_enable(jump_enable), .jump_addr(jump_addr),
    .iw_out(iw_out), .pc_out(pc_out),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .wb_reg_out(wb_reg_out), .wb_enable_out(wb_enable_out),
    .valid_out(valid_out), .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] iw;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  wbr;
    logic        wbe;
    logic        vld;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: an entry issued in cycle c is visible after the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("iw_out", iw_out, e.iw);
        chk("pc_out", pc_out, e.pc);
        chk("valid_out", {31'd0, valid_out}, {31'd0, e.vld});
        chk("wb_enable_out", {31'd0, wb_enable_out}, {31'd0, e.wbe});
        chk("wb_reg_out", {27'd0, wb_reg_out}, {27'd0, e.wbr});
        chk("illegal_out", {31'd0, illegal_out}, {31'd0, e.ill});
        if (e.vld) begin
          chk("rs1_data_out", rs1_data_out, e.rs1);
          chk("rs2_data_out", rs2_data_out, e.rs2);
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, r1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [4:0] rd);
    return {7'd0, r2, r1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Present one instruction now, queue its expected EX slot, check redirect.
  task automatic drive_push(
    input logic [31:0] iw, input logic [31:0] pc,
    input logic we, input logic [4:0] wr, input logic [31:0] wd,
    input logic fe, input logic [4:0] fr, input logic [31:0] fd,
    input logic sq, input logic [31:0] e_rs1, input logic [31:0] e_rs2,
    input logic [4:0] e_wbr, input logic e_wbe, input logic e_ill,
    input logic e_je, input logic [31:0] e_ja);
    exp_t e;
    iw_in = iw; pc_in = pc;
    wb_enable = we; wb_reg = wr; wb_data = wd;
    ex_fwd_enable = fe; ex_fwd_reg = fr; ex_fwd_data = fd;
    e.pc  = pc;
    e.rs1 = e_rs1;
    e.rs2 = e_rs2;
    e.cyc = cyc;
    if (sq) begin
      e.iw = NOP; e.vld = 1'b0; e.wbe = 1'b0; e.wbr = '0; e.ill = 1'b0;
    end else begin
      e.iw = iw; e.vld = 1'b1; e.wbe = e_wbe; e.wbr = e_wbr; e.ill = e_ill;
    end
    q.push_back(e);
    #1;
    chk("jump_enable", {31'd0, jump_enable}, {31'd0, e_je});
    chk("jump_addr", jump_addr, e_ja);
  endtask

  task automatic issue(
    input logic [31:0] iw, input logic [31:0] pc,
    input logic we, input logic [4:0] wr, input logic [31:0] wd,
    input logic fe, input logic [4:0] fr, input logic [31:0] fd,
    input logic sq, input logic [31:0] e_rs1, input logic [31:0] e_rs2,
    input logic [4:0] e_wbr, input logic e_wbe, input logic e_ill,
    input logic e_je, input logic [31:0] e_ja);
    @(posedge clk);
    #1;
    drive_push(iw, pc, we, wr, wd, fe, fr, fd, sq, e_rs1, e_rs2, e_wbr, e_wbe, e_ill, e_je, e_ja);
  endtask

  task automatic reset_chk();
    chk("rst iw_out", iw_out, NOP);
    chk("rst pc_out", pc_out, 32'h0);
    chk("rst rs1_data_out", rs1_data_out, 32'h0);
    chk("rst rs2_data_out", rs2_data_out, 32'h0);
    chk("rst wb_reg_out", {27'd0, wb_reg_out}, 32'h0);
    chk("rst wb_enable_out", {31'd0, wb_enable_out}, 32'h0);
    chk("rst valid_out", {31'd0, valid_out}, 32'h0);
    chk("rst illegal_out", {31'd0, illegal_out}, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      tests++;
      errors++;
      $display("FAIL drain: %0d expected slots never observed, required 0", q.size());
      q.delete();
    end
  endtask

  logic [31:0] fwd_exp;

  initial begin
`ifdef RV32I_ID_FWD_EN
    fwd_exp = 32'h55;
`else
    fwd_exp = 32'h66;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset_chk();
    @(negedge clk);
    reset = 1'b0;

    //    iw                                   pc        we  wr     wd            fe  fr    fd      sq  rs1           rs2        wbr    wbe  ill  je  ja
    issue(enc_i(12'd1, 5'd5, 3'b000, 5'd6, 7'b0010011), 32'h000, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 32'hDEADBEEF, 32'h0, 5'd6, 1, 0, 0, 32'h0);
    issue(enc_i(12'd0, 5'd5, 3'b000, 5'd7, 7'b0010011), 32'h004, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'hDEADBEEF, 32'h0, 5'd7, 1, 0, 0, 32'h0);
    issue(enc_r(5'd0, 5'd0, 5'd8),                      32'h008, 1, 5'd0, 32'h123, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 5'd8, 1, 0, 0, 32'h0);
    // JAL then its wrong-path follower (another JAL that must not chain)
    issue(enc_j(21'h20, 5'd1),                          32'h100, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 5'd1, 1, 0, 1, 32'h120);
    issue(enc_j(21'h20, 5'd1),                          32'h104, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
    issue(NOP,                                          32'h108, 1, 5'd1, 32'd5, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
    issue(NOP,                                          32'h10C, 1, 5'd2, 32'd5, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
    // BEQ x1,x2,-8: rd field of this encoding is 25
    issue(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000),          32'h200, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'd5, 32'd5, 5'd25, 0, 0, 1, 32'h1F8);
    issue(NOP,                                          32'h204, 1, 5'd1, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
    issue(NOP,                                          32'h208, 1, 5'd2, 32'd1, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
    // BLT -1 < 1 taken; BLTU 0xFFFFFFFF < 1 not taken
    issue(enc_b(13'd16, 5'd2, 5'd1, 3'b100),            32'h300, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'hFFFFFFFF, 32'd1, 5'd16, 0, 0, 1, 32'h310);
    issue(NOP,                                          32'h304, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
    issue(enc_b(13'd16, 5'd2, 5'd1, 3'b110),            32'h400, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'hFFFFFFFF, 32'd1, 5'd16, 0, 0, 0, 32'h0);
    // JALR x0,x3,3 with x3 arriving by write-through; rs2 field is also 3
    issue(enc_i(12'd3, 5'd3, 3'b000, 5'd0, 7'b1100111), 32'h500, 1, 5'd3, 32'h1000, 0, 5'd0, 32'h0, 0, 32'h1000, 32'h1000, 5'd0, 0, 0, 1, 32'h1002);
    issue(32'h0,                                        32'h504, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
    issue(32'h0,                                        32'h508, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0, 1, 0, 32'h0);
    // EX forward vs writeback on x7 in the same cycle
    issue(enc_i(12'd0, 5'd7, 3'b000, 5'd9, 7'b0010011), 32'h600, 1, 5'd7, 32'h66, 1, 5'd7, 32'h55, 0, fwd_exp, 32'h0, 5'd9, 1, 0, 0, 32'h0);
    issue(enc_r(5'd7, 5'd7, 5'd10),                     32'h604, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h66, 32'h66, 5'd10, 1, 0, 0, 32'h0);
    // LUI x11: rs1 field 8 (x8=0), rs2 field 3 (x3=0x1000)
    issue({20'h12345, 5'd11, 7'b0110111},               32'h608, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h1000, 5'd11, 1, 0, 0, 32'h0);
    issue(enc_b(13'd8, 5'd2, 5'd1, 3'b111),             32'h700, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'hFFFFFFFF, 32'd1, 5'd8, 0, 0, 1, 32'h708);
    issue(NOP,                                          32'h704, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
    drain();

    // Taken JAL loads into EX and arms squash; reset then lands mid-cycle.
    iw_in = enc_j(21'h20, 5'd1); pc_in = 32'h900;
    wb_enable = 1'b0; ex_fwd_enable = 1'b0;
    #1;
    chk("pre-reset jump_enable", {31'd0, jump_enable}, 32'd1);
    @(posedge clk);
    #3;
    chk("pre-reset valid_out", {31'd0, valid_out}, 32'd1);
    reset = 1'b1;
    #1;
    reset_chk();
    @(negedge clk);
    reset = 1'b0;
    // First post-reset instruction must not be treated as squashed.
    drive_push(enc_j(21'h20, 5'd1), 32'h800, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 5'd1, 1, 0, 1, 32'h820);
    issue(NOP,                      32'h804, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
    // Register file was cleared by reset.
    issue(enc_r(5'd2, 5'd1, 5'd12), 32'h808, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 5'd12, 1, 0, 0, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
